// File: rtl/ahb_ifetch_if.sv
// AHB-Lite bus bundle between the instruction fetch master and its memory slave.
interface ahb_ifetch_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (output HADDR, HTRANS, HSIZE, HWRITE, input HREADY, HRDATA, HRESP);
  modport slave  (input HADDR, HTRANS, HSIZE, HWRITE, output HREADY, HRDATA, HRESP);
endinterface

// File: rtl/ahb_ifetch.sv
// AHB-Lite instruction fetch unit: single-outstanding word reads into a 2-entry buffer.
// Define IFETCH_ERR_EN to enable bus-error handling (sticky fetch_err, ERR state).
module ahb_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         instr_ready,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output logic [5:0]   opcode,
  output logic [5:0]   funct,
  output logic         fetch_err,
  ahb_ifetch_if.master bus
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, DROP, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [1:0]  count, count_nxt, cnt_push;
  logic        rd_ptr, wr_ptr;
  logic        push, pop, err_hit, err_set;
  logic [1:0]  htrans;
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];

`ifdef IFETCH_ERR_EN
  assign err_hit = bus.HRESP;
`else
  logic unused_sig;
  assign err_hit    = 1'b0;
  assign unused_sig = bus.HRESP ^ err_set;
`endif

  assign pop       = instr_valid && instr_ready;
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};
  // occupancy if the returning word is pushed this cycle
  assign cnt_push  = count + 2'd1 - {1'b0, pop};

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    err_set   = 1'b0;
    htrans    = 2'b00;
    case (state)
      IDLE: if (redirect_valid || count < 2'd2) state_nxt = ADDR;
      ADDR: begin
        htrans = 2'b10;
        if (bus.HREADY) state_nxt = redirect_valid ? DROP : DATA;
      end
      DATA: begin
        if (redirect_valid) state_nxt = DROP;
        else if (bus.HREADY) begin
          if (err_hit) begin
            err_set   = 1'b1;
            state_nxt = ERR;
          end else begin
            push      = 1'b1;
            state_nxt = (cnt_push < 2'd2) ? ADDR : IDLE;
          end
        end
      end
      DROP: if (bus.HREADY) state_nxt = ADDR;
      ERR:  if (redirect_valid) state_nxt = ADDR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_valid)   fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (push)        fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // a redirect flushes the buffer, overriding any same-cycle pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (redirect_valid) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      fifo_instr[wr_ptr] <= bus.HRDATA;
      fifo_pc[wr_ptr]    <= fetch_pc;
    end
  end

`ifdef IFETCH_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 fetch_err <= 1'b0;
    else if (redirect_valid) fetch_err <= 1'b0;
    else if (err_set)        fetch_err <= 1'b1;
  end
`else
  assign fetch_err = 1'b0;
`endif

  assign instr_valid = (count != 2'd0);
  assign instr       = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'h0;
  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];

  assign bus.HADDR  = fetch_pc;
  assign bus.HTRANS = htrans;
  assign bus.HSIZE  = 3'b010;
  assign bus.HWRITE = 1'b0;
endmodule

// File: tb/tb_ahb_ifetch.sv
// Self-checking bench for ahb_ifetch: startup vector table, hand-written corner sequences,
// and a randomized run checked against an instruction-stream reference model.
module tb_ahb_ifetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_ready = 1'b0;
  logic        instr_valid, fetch_err;
  logic [31:0] instr, instr_pc;
  logic [5:0]  opcode, funct;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_ifetch_if bus ();

  ahb_ifetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct(funct), .fetch_err(fetch_err), .bus(bus.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return {6'd35, 5'd1, 5'd2, 16'h012A};
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // memory slave: programmable wait states, optional address-phase stall, error address
  logic        dphase, force_low, err_en, ws_rand;
  logic [31:0] daddr, err_addr;
  int          wcnt, ws_fixed;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dphase <= 1'b0;
      daddr  <= 32'h0;
      wcnt   <= 0;
    end else if (bus.HREADY) begin
      dphase <= (bus.HTRANS == 2'b10);
      daddr  <= bus.HADDR;
      wcnt   <= ws_rand ? int'($urandom_range(0, 2)) : ws_fixed;
    end else if (wcnt > 0) begin
      wcnt <= wcnt - 1;
    end
  end

  assign bus.HREADY = !force_low && !(dphase && wcnt != 0);
  assign bus.HRDATA = dphase ? mem_word(daddr) : 32'hDEAD_BEEF;
  assign bus.HRESP  = dphase && err_en && (daddr == err_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, expected event", name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    force_low = 1'b0;
    err_en = 1'b0;
    err_addr = 32'h0;
    ws_rand = 1'b0;
    ws_fixed = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_nonseq(input string name, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (bus.HTRANS == 2'b10) begin ok = 1'b1; return; end
    end
    timeout(name);
  endtask

  task automatic wait_valid(input string name, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (instr_valid) begin ok = 1'b1; return; end
    end
    timeout(name);
  endtask

  typedef struct {
    logic        ready;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t        vtab [10];
  logic [31:0] exp_instr, exp_pc, prev_addr;
  logic        ok, prev_stall;
  int          pops;

  initial begin
    // startup, zero-wait slave, decode always ready
    vtab[0] = '{1'b1, 2'b00, 32'h00, 1'b0, 32'h0};
    vtab[1] = '{1'b1, 2'b10, 32'h00, 1'b0, 32'h0};
    vtab[2] = '{1'b1, 2'b00, 32'h00, 1'b0, 32'h0};
    vtab[3] = '{1'b1, 2'b10, 32'h04, 1'b1, 32'h0};
    vtab[4] = '{1'b1, 2'b00, 32'h04, 1'b0, 32'h0};
    vtab[5] = '{1'b1, 2'b10, 32'h08, 1'b1, 32'h4};
    vtab[6] = '{1'b1, 2'b00, 32'h08, 1'b0, 32'h0};
    vtab[7] = '{1'b1, 2'b10, 32'h0C, 1'b1, 32'h8};
    vtab[8] = '{1'b1, 2'b00, 32'h0C, 1'b0, 32'h0};
    vtab[9] = '{1'b1, 2'b10, 32'h10, 1'b1, 32'hC};

    do_reset();
    chk("reset_fetch_err", {31'h0, fetch_err}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      instr_ready = vtab[i].ready;
      #1;
      exp_instr = vtab[i].valid ? mem_word(vtab[i].pc) : 32'h0;
      chk($sformatf("tab%0d_htrans", i), {30'h0, bus.HTRANS}, {30'h0, vtab[i].htrans});
      chk($sformatf("tab%0d_haddr", i), bus.HADDR, vtab[i].haddr);
      chk($sformatf("tab%0d_valid", i), {31'h0, instr_valid}, {31'h0, vtab[i].valid});
      chk($sformatf("tab%0d_pc", i), instr_pc, vtab[i].valid ? vtab[i].pc : 32'h0);
      chk($sformatf("tab%0d_instr", i), instr, exp_instr);
      chk($sformatf("tab%0d_opcode", i), {26'h0, opcode}, {26'h0, exp_instr[31:26]});
      chk($sformatf("tab%0d_funct", i), {26'h0, funct}, {26'h0, exp_instr[5:0]});
    end
    chk("opcode35", {26'h0, opcode}, 32'd35);
    chk("funct_2a", {26'h0, funct}, 32'h2A);

    // decode stalled: buffer fills to exactly two entries and fetch idles
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      if (c >= 6) begin
        chk($sformatf("full_htrans_c%0d", c), {30'h0, bus.HTRANS}, 32'h0);
        chk($sformatf("full_valid_c%0d", c), {31'h0, instr_valid}, 32'h1);
        chk($sformatf("full_pc_c%0d", c), instr_pc, 32'h0);
      end
    end
    @(negedge clk); instr_ready = 1'b1; #1;
    chk("drain0_pc", instr_pc, 32'h0);
    @(negedge clk); #1;
    chk("drain1_valid", {31'h0, instr_valid}, 32'h1);
    chk("drain1_pc", instr_pc, 32'h4);
    @(negedge clk); #1;
    chk("drain2_empty", {31'h0, instr_valid}, 32'h0);
    chk("drain2_instr_zero", instr, 32'h0);
    chk("drain2_refetch", bus.HADDR, 32'h8);

    // redirect during a 3-wait-state data phase
    do_reset();
    ws_fixed = 3;
    instr_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (bus.HTRANS == 2'b10) && bus.HREADY;
    end
    if (!ok) timeout("redir_addr_phase");
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1003;
    #1;
    chk("redir_ws_stall", {31'h0, bus.HREADY}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    ws_fixed = 0;
    #1;
    chk("redir_drop_idle", {30'h0, bus.HTRANS}, 32'h0);
    wait_nonseq("redir_nonseq", 20, ok);
    if (ok) chk("redir_haddr", bus.HADDR, 32'h0000_1000);
    wait_valid("redir_valid", 20, ok);
    if (ok) begin
      chk("redir_pc", instr_pc, 32'h0000_1000);
      chk("redir_instr", instr, mem_word(32'h0000_1000));
    end

`ifdef IFETCH_ERR_EN
    // bus error at 0x8 stops fetching until a redirect
    do_reset();
    err_en = 1'b1;
    err_addr = 32'h8;
    instr_ready = 1'b1;
    pops = 0;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk); #1;
      if (instr_valid && instr_ready) pops++;
      ok = fetch_err;
    end
    if (!ok) timeout("err_flag");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (instr_valid && instr_ready) pops++;
      chk($sformatf("err_no_fetch%0d", i), {30'h0, bus.HTRANS}, 32'h0);
      chk($sformatf("err_sticky%0d", i), {31'h0, fetch_err}, 32'h1);
    end
    chk("err_pops", pops, 32'd2);
    chk("err_empty", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("err_cleared", {31'h0, fetch_err}, 32'h0);
    chk("err_resume_htrans", {30'h0, bus.HTRANS}, 32'h2);
    chk("err_resume_haddr", bus.HADDR, 32'h40);
    err_en = 1'b0;
`else
    // without error handling HRESP is ignored and the word is delivered
    do_reset();
    err_en = 1'b1;
    err_addr = 32'h8;
    instr_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk); #1;
      chk($sformatf("noerr_flag%0d", i), {31'h0, fetch_err}, 32'h0);
      if (instr_valid && instr_pc == 32'h8) begin
        ok = 1'b1;
        chk("noerr_instr", instr, mem_word(32'h8));
      end
    end
    if (!ok) timeout("noerr_push");
    err_en = 1'b0;
`endif

    // reset while the address phase is stalled
    do_reset();
    instr_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (bus.HTRANS == 2'b10) && (bus.HADDR == 32'h8);
    end
    if (!ok) timeout("rst_reach_addr8");
    force_low = 1'b1;
    @(negedge clk); #1;
    chk("rst_stall_htrans", {30'h0, bus.HTRANS}, 32'h2);
    chk("rst_stall_haddr", bus.HADDR, 32'h8);
    rst = 1'b1;
    #1;
    chk("rst_async_htrans", {30'h0, bus.HTRANS}, 32'h0);
    chk("rst_async_haddr", bus.HADDR, RESET_PC);
    chk("rst_async_valid", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    force_low = 1'b0;
    wait_nonseq("rst_nonseq", 10, ok);
    if (ok) chk("rst_first_haddr", bus.HADDR, RESET_PC);
    wait_valid("rst_valid", 10, ok);
    if (ok) chk("rst_first_pc", instr_pc, RESET_PC);

    // randomized traffic against an instruction-stream model
    do_reset();
    ws_rand = 1'b1;
    exp_pc = RESET_PC;
    prev_stall = 1'b0;
    prev_addr = 32'h0;
    pops = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc = $urandom;
      force_low = ($urandom_range(0, 7) == 0);
      #1;
      if (prev_stall) chk("rnd_addr_hold", bus.HADDR, prev_addr);
      chk("rnd_hsize_hwrite", {28'h0, bus.HWRITE, bus.HSIZE}, 32'h2);
      if (instr_valid && instr_ready) begin
        chk("rnd_pc", instr_pc, exp_pc);
        chk("rnd_instr", instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end else if (!instr_valid) begin
        chk("rnd_empty_instr", instr, 32'h0);
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      prev_stall = (bus.HTRANS == 2'b10) && !bus.HREADY && !redirect_valid;
      prev_addr = bus.HADDR;
    end
    redirect_valid = 1'b0;
    force_low = 1'b0;
    chk("rnd_progress", {31'h0, pops > 200}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
